tone_gen: RTL and testbench

- Converts a pitch word in centi-Hz into a 50%-duty square-wave tone on the Nexys A7 audio path. Example: 44000 = 440.00 Hz.
- Sits directly downstream of the note-index-to-frequency scaler and upstream of the PWM/audio output pin.
- Computes the half-period in clock cycles with a sequential restoring divider, then toggles the output from a cycle counter.
- Pitch changes are glitch-free and gated by a note-on signal.

---
 rtl/tone_gen.sv | 154 +++++++++++++++
 tb/tb_tone_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_gen.sv
// tone_gen: converts a centi-Hz pitch word into a 50%-duty square wave.
// The half-period (CLK_HZ*50 / freq_chz) comes from a bit-serial restoring divider.
module tone_gen #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned MIN_CHZ = 100,
  parameter int unsigned DVD_W   = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freq_valid,
  output logic        freq_ready,
  input  logic [31:0] freq_chz,
  input  logic        gate,
  output logic        tone_out,
  output logic        busy,
  output logic [31:0] half_period
);

  localparam logic [DVD_W-1:0] DVD     = DVD_W'(64'(CLK_HZ) * 64'd50);
  localparam int unsigned      IT_W    = $clog2(DVD_W);
  localparam logic [IT_W-1:0]  IT_LAST = IT_W'(DVD_W - 1);
  localparam logic [DVD_W-1:0] HP_MAX  = DVD_W'(64'hFFFF_FFFF);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_PLAY} state_t;

  state_t             state_q, state_d;
  logic [31:0]        dvs_q, dvs_d;
  logic [31:0]        rem_q, rem_d;
  logic [DVD_W-1:0]   quo_q, quo_d;
  logic [DVD_W-1:0]   dvd_sh_q, dvd_sh_d;
  logic [IT_W-1:0]    it_q, it_d;
  logic               ld_q, ld_d;
  logic [31:0]        hp_q, hp_d;
  logic               pv_q, pv_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               tone_q, tone_d;

  logic               accept, playable, take;
  logic [32:0]        rem_sh, rem_sub;
  logic [31:0]        hp_clamp;

  assign freq_ready  = (state_q != S_DIV);
  assign busy        = (state_q == S_DIV);
  assign tone_out    = tone_q;
  assign half_period = hp_q;
  assign accept      = freq_valid && freq_ready;
  assign playable    = (freq_chz >= 32'(MIN_CHZ));

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  assign rem_sh  = {rem_q, dvd_sh_q[DVD_W-1]};
  assign rem_sub = rem_sh - {1'b0, dvs_q};
  assign take    = (rem_sh >= {1'b0, dvs_q});

  always_comb begin
    if (quo_q > HP_MAX)
      hp_clamp = '1;
    else if (quo_q == '0)
      hp_clamp = 32'd1;
    else
      hp_clamp = quo_q[31:0];
  end

  always_comb begin
    state_d  = state_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvd_sh_d = dvd_sh_q;
    it_d     = it_q;
    ld_d     = 1'b0;
    hp_d     = hp_q;
    pv_d     = pv_q;

    // Finished quotient lands one cycle after the last step (first PLAY cycle).
    if (ld_q) begin
      hp_d = hp_clamp;
      pv_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_PLAY: begin
        if (accept) begin
          if (playable) begin
            state_d  = S_DIV;
            dvs_d    = freq_chz;
            rem_d    = '0;
            quo_d    = '0;
            dvd_sh_d = DVD;
            it_d     = '0;
          end else begin
            state_d = S_IDLE;
            pv_d    = 1'b0;
            hp_d    = '0;
          end
        end
      end
      S_DIV: begin
        rem_d    = take ? rem_sub[31:0] : rem_sh[31:0];
        quo_d    = {quo_q[DVD_W-2:0], take};
        dvd_sh_d = {dvd_sh_q[DVD_W-2:0], 1'b0};
        it_d     = it_q + IT_W'(1);
        if (it_q == IT_LAST) begin
          state_d = S_PLAY;
          ld_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tone counter keeps running across re-pitches; >= makes a shrinking period toggle at once.
  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (!gate || !pv_q) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (cnt_q >= hp_q - 32'd1) begin
      cnt_d  = '0;
      tone_d = ~tone_q;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvd_sh_q <= '0;
      it_q     <= '0;
      ld_q     <= 1'b0;
      hp_q     <= '0;
      pv_q     <= 1'b0;
      cnt_q    <= '0;
      tone_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvd_sh_q <= dvd_sh_d;
      it_q     <= it_d;
      ld_q     <= ld_d;
      hp_q     <= hp_d;
      pv_q     <= pv_d;
      cnt_q    <= cnt_d;
      tone_q   <= tone_d;
    end
  end

endmodule

// File: tb/tb_tone_gen.sv
// Scoreboard bench for tone_gen at CLK_HZ=100 kHz so tone periods stay short.
// Stimulus pushes expected half_period updates and tone edges; a monitor pops and compares.
`timescale 1ns/1ps
module tb_tone_gen;
  localparam int unsigned CLK_HZ  = 100_000;
  localparam int unsigned MIN_CHZ = 100;
  localparam int unsigned DVD_W   = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        freq_valid = 1'b0;
  logic [31:0] freq_chz = '0;
  logic        gate = 1'b0;
  logic        freq_ready, tone_out, busy;
  logic [31:0] half_period;

  tone_gen #(.CLK_HZ(CLK_HZ), .MIN_CHZ(MIN_CHZ), .DVD_W(DVD_W)) dut (
    .clk(clk), .rst_n(rst_n), .freq_valid(freq_valid), .freq_ready(freq_ready),
    .freq_chz(freq_chz), .gate(gate), .tone_out(tone_out), .busy(busy),
    .half_period(half_period)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] val; int at; } hp_exp_t;
  typedef struct { logic lvl; int at; } tn_exp_t;
  hp_exp_t hp_q[$];
  tn_exp_t tn_q[$];
  bit hp_en = 1'b0, tn_en = 1'b0;
  int n_tests = 0, n_fail = 0;

  task automatic push_hp(input logic [31:0] v, input int at);
    hp_exp_t t; t.val = v; t.at = at; hp_q.push_back(t);
  endtask
  task automatic push_tn(input logic l, input int at);
    tn_exp_t t; t.lvl = l; t.at = at; tn_q.push_back(t);
  endtask

  // Monitor: every half_period change / tone edge must match the queue front.
  initial begin
    logic [31:0] hp_prev;
    logic        tn_prev;
    hp_exp_t     he;
    tn_exp_t     te;
    hp_prev = '0; tn_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (hp_en && half_period !== hp_prev) begin
        n_tests++;
        if (hp_q.size() == 0) begin
          n_fail++;
          $display("FAIL hp_unexpected: got %0d at cyc %0d, none expected", half_period, cyc);
        end else begin
          he = hp_q.pop_front();
          if (half_period !== he.val || cyc != he.at) begin
            n_fail++;
            $display("FAIL hp_update: got %0d at cyc %0d, exp %0d at cyc %0d",
                     half_period, cyc, he.val, he.at);
          end
        end
      end
      if (tn_en && tone_out !== tn_prev) begin
        n_tests++;
        if (tn_q.size() == 0) begin
          n_fail++;
          $display("FAIL tone_unexpected: got edge to %0b at cyc %0d, none expected", tone_out, cyc);
        end else begin
          te = tn_q.pop_front();
          if (tone_out !== te.lvl || cyc != te.at) begin
            n_fail++;
            $display("FAIL tone_edge: got %0b at cyc %0d, exp %0b at cyc %0d",
                     tone_out, cyc, te.lvl, te.at);
          end
        end
      end
      hp_prev = half_period;
      tn_prev = tone_out;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d exp %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic to_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge e.
  task automatic offer(input logic [31:0] f, input logic [31:0] hp_exp, input int lat, output int e);
    chk("offer_ready", freq_ready, 1);
    freq_valid = 1'b1;
    freq_chz   = f;
    @(posedge clk);
    #1 e = cyc;
    if (lat >= 0) push_hp(hp_exp, e + lat);
    @(negedge clk);
    freq_valid = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int k;
    k = 0;
    while ((hp_q.size() != 0 || tn_q.size() != 0) && k < maxc) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (hp_q.size() != 0 || tn_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d hp + %0d tone events pending, exp 0",
               hp_q.size(), tn_q.size());
      hp_q.delete();
      tn_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by %0t, exp finish", $time);
    $fatal(1);
  end

  initial begin
    int e, x, u, nb, nr, bad;
    @(negedge clk);
    chk("rst_tone", tone_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", freq_ready, 1);
    chk("rst_hp", half_period, 0);
    rst_n = 1'b1;
    tick(2);
    hp_en = 1'b1;

    // 440 Hz: 40 busy cycles, update at +41, tone rises hp later.
    gate = 1'b1; tn_en = 1'b1;
    offer(32'd44000, 32'd113, 41, e);
    push_tn(1'b1, e + 41 + 113);
    push_tn(1'b0, e + 41 + 226);
    push_tn(1'b1, e + 41 + 339);
    nb = 0; nr = 0;
    for (int i = 0; i < 45; i++) begin
      nb += int'(busy);
      nr += int'(!freq_ready);
      @(negedge clk);
    end
    chk("div_busy_cycles", nb, 40);
    chk("div_notready_cycles", nr, 40);
    drain(600);
    tn_en = 1'b0;

    // A0 then C8 while playing; old period still spaces the tone during the divide.
    gate = 1'b0;
    offer(32'd2750, 32'd1818, 41, e);
    drain(100);
    to_cyc(e + 50);
    x = cyc;
    gate = 1'b1; tn_en = 1'b1;
    push_tn(1'b1, x + 1818);
    push_tn(1'b0, x + 3636);
    to_cyc(x + 3617);
    offer(32'd418601, 32'd11, 41, e);
    u = e + 41;
    push_tn(1'b1, u + 1);
    push_tn(1'b0, u + 12);
    push_tn(1'b1, u + 23);
    drain(200);
    tn_en = 1'b0;

    // Rest word while playing.
    offer(32'd1, 32'd0, 0, e);
    chk("rest_busy", busy, 0);
    tick(1);
    chk("rest_tone", tone_out, 0);
    chk("rest_hp", half_period, 0);
    chk("rest_ready", freq_ready, 1);
    chk("rest_busy2", busy, 0);

    // Gate off for 500 cycles, then restart timing from the gate edge.
    offer(32'd44000, 32'd113, 41, e);
    drain(100);
    tick(200);
    gate = 1'b0;
    tick(1);
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      if (tone_out !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("gate_low_tone_high_cycles", bad, 0);
    tn_en = 1'b1;
    x = cyc;
    gate = 1'b1;
    push_tn(1'b1, x + 113);
    push_tn(1'b0, x + 226);
    drain(400);
    tn_en = 1'b0;

    // Async reset in the middle of a divide.
    hp_en = 1'b0;
    offer(32'd44000, 32'd0, -1, e);
    to_cyc(e + 20);
    chk("mid_div_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tone", tone_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", freq_ready, 1);
    chk("arst_hp", half_period, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    hp_en = 1'b1;
    offer(32'd26163, 32'd191, 41, e);
    drain(100);

    // freq_valid held through a divide: only the accepting-edge word counts.
    freq_valid = 1'b1;
    freq_chz   = 32'd2750;
    @(posedge clk);
    #1 e = cyc;
    push_hp(32'd1818, e + 41);
    push_hp(32'd113, e + 82);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      freq_chz = (i % 2 == 1) ? 32'd1 : 32'd418601 + 32'(i);
    end
    @(negedge clk);
    chk("first_play_ready", freq_ready, 1);
    freq_chz = 32'd44000;
    @(negedge clk);
    chk("reaccept_busy", busy, 1);
    freq_valid = 1'b0;
    drain(100);

    // Boundaries: 99 is a rest, 100 plays, huge pitch clamps to 1.
    gate = 1'b0;
    offer(32'd99, 32'd0, 0, e);
    offer(32'd99, 32'd0, -1, e);
    tick(1);
    chk("idle_rest_busy", busy, 0);
    chk("idle_rest_ready", freq_ready, 1);
    offer(32'd100, 32'd50000, 41, e);
    drain(100);
    offer(32'hFFFF_FFFF, 32'd1, 41, e);
    drain(100);

    // Gate falls during a divide; division still completes.
    gate = 1'b1;
    tick(3);
    offer(32'd44000, 32'd113, 41, e);
    to_cyc(e + 10);
    gate = 1'b0;
    tick(1);
    chk("gate_fall_div_tone", tone_out, 0);
    chk("gate_fall_div_busy", busy, 1);
    drain(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
